// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with a small bank of word registers.
// reg[0] is a read-only ID word; reg[1..NUM_REGS-1] are read/write.
// Optional macro APB_SLAVE_WAIT_EN enables the WAIT_STATES counter; when it is
// undefined every transfer completes in the first ACCESS cycle.
// P_READY, P_SLVERR and P_RDATA are registered, so no input-to-output paths exist.
module apb_reg_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic                  P_CLK,
    input  logic                  P_RESET,
    input  logic                  P_SELx,
    input  logic                  P_ENABLE,
    input  logic                  P_WRITE,
    input  logic [ADDR_WIDTH-1:0] P_ADDR,
    input  logic [DATA_WIDTH-1:0] P_WDATA,
    output logic [DATA_WIDTH-1:0] P_RDATA,
    output logic                  P_READY,
    output logic                  P_SLVERR
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    // Elaboration-time parameter sanity checks
    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb_reg_slave: DATA_WIDTH must be 32");
    end
    if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
        $error("apb_reg_slave: NUM_REGS must be a power of two >= 2");
    end
    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("apb_reg_slave: WAIT_STATES must be 0..15");
    end

`ifdef APB_SLAVE_WAIT_EN
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);
    localparam logic READY_AT_SETUP = (CNT_INIT == '0);
    logic [CNT_W-1:0] r_cnt;
`else
    localparam logic READY_AT_SETUP = 1'b1;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic                  r_ready;
    logic                  r_slverr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;

    // Word index and error decode of the address presented in the setup cycle
    assign w_idx = P_ADDR[IDX_W+1:2];
    assign w_err = (P_ADDR[1:0] != 2'b00)
                 || (P_ADDR >= ADDR_WIDTH'(4 * NUM_REGS))
                 || (P_WRITE && (P_ADDR == '0));

    // Register readback: index 0 is the constant ID word
    function automatic logic [DATA_WIDTH-1:0] reg_val(input logic [IDX_W-1:0] idx);
        return (idx == '0) ? ID_VALUE : r_regs[idx];
    endfunction

    // Transfer FSM, register bank and registered response outputs
    always_ff @(posedge P_CLK or posedge P_RESET) begin
        if (P_RESET) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_rdata  <= '0;
`ifdef APB_SLAVE_WAIT_EN
            r_cnt    <= '0;
`endif
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (P_SELx && !P_ENABLE) begin
                        r_state <= ACCESS;
                        r_idx   <= w_idx;
                        r_write <= P_WRITE;
                        r_wdata <= P_WDATA;
                        r_err   <= w_err;
`ifdef APB_SLAVE_WAIT_EN
                        r_cnt   <= CNT_INIT;
`endif
                        if (READY_AT_SETUP) begin
                            r_ready  <= 1'b1;
                            r_slverr <= w_err;
                            r_rdata  <= (!P_WRITE && !w_err) ? reg_val(w_idx) : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!P_SELx) begin
                        // Abort: drop the transfer without touching the bank
                        r_state  <= IDLE;
                        r_ready  <= 1'b0;
                        r_slverr <= 1'b0;
                        r_rdata  <= '0;
`ifdef APB_SLAVE_WAIT_EN
                        r_cnt    <= '0;
`endif
                    end else if (P_ENABLE && r_ready) begin
                        if (r_write && !r_err) begin
                            r_regs[r_idx] <= r_wdata;
                        end
                        r_state  <= IDLE;
                        r_ready  <= 1'b0;
                        r_slverr <= 1'b0;
                        r_rdata  <= '0;
`ifdef APB_SLAVE_WAIT_EN
                    end else if (P_ENABLE && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_ready  <= 1'b1;
                            r_slverr <= r_err;
                            r_rdata  <= (!r_write && !r_err) ? reg_val(r_idx) : '0;
                        end
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign P_READY  = r_ready;
    assign P_SLVERR = r_slverr;
    assign P_RDATA  = r_rdata;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: reference register model plus a
// scoreboard queue of expected responses, compared when P_READY is seen.
module tb_apb_reg_slave;

    localparam int unsigned WAIT = 1;
    localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLAVE_WAIT_EN
    localparam int EXP_LEN = 2 + int'(WAIT);
`else
    localparam int EXP_LEN = 2;
`endif

    logic        P_CLK;
    logic        P_RESET;
    logic        P_SELx;
    logic        P_ENABLE;
    logic        P_WRITE;
    logic [31:0] P_ADDR;
    logic [31:0] P_WDATA;
    logic [31:0] P_RDATA;
    logic        P_READY;
    logic        P_SLVERR;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [16];
    int          n_checks;
    int          n_errors;

    apb_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .NUM_REGS   (16),
        .WAIT_STATES(WAIT),
        .ID_VALUE   (ID)
    ) u_dut (
        .P_CLK   (P_CLK),
        .P_RESET (P_RESET),
        .P_SELx  (P_SELx),
        .P_ENABLE(P_ENABLE),
        .P_WRITE (P_WRITE),
        .P_ADDR  (P_ADDR),
        .P_WDATA (P_WDATA),
        .P_RDATA (P_RDATA),
        .P_READY (P_READY),
        .P_SLVERR(P_SLVERR)
    );

    initial P_CLK = 1'b0;
    always #5 P_CLK = ~P_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic align();
        @(posedge P_CLK);
        #1;
    endtask

    // One complete APB transfer; caller is positioned just after a rising edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input string tag);
        exp_t        e;
        logic        err;
        logic [3:0]  idx;
        int          cyc;
        idx = addr[5:2];
        err = (addr[1:0] != 2'b00) || (addr >= 32'h40) || (wr && (addr == 32'h0));
        e.slverr = err;
        e.rdata  = (!wr && !err) ? ((idx == 4'd0) ? ID : model[idx]) : 32'h0;
        sb.push_back(e);
        if (wr && !err) model[idx] = wdata;

        P_SELx   = 1'b1;
        P_ENABLE = 1'b0;
        P_WRITE  = wr;
        P_ADDR   = addr;
        P_WDATA  = wdata;
        align();
        P_ENABLE = 1'b1;
        cyc = 2;
        while (!P_READY && cyc < 40) begin
            align();
            cyc++;
        end
        e = sb.pop_front();
        check({tag, "_ready"},  32'(P_READY), 32'h1);
        check({tag, "_slverr"}, 32'(P_SLVERR), 32'(e.slverr));
        check({tag, "_rdata"},  P_RDATA, e.rdata);
        check({tag, "_len"},    32'(cyc), 32'(EXP_LEN));
        align();
        P_SELx   = 1'b0;
        P_ENABLE = 1'b0;
        check({tag, "_done"}, 32'(P_READY), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();
        P_RESET  = 1'b1;
        P_SELx   = 1'b0;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b0;
        P_ADDR   = 32'h0;
        P_WDATA  = 32'h0;
        #12;
        check("rst_ready",  32'(P_READY), 32'h0);
        check("rst_slverr", 32'(P_SLVERR), 32'h0);
        check("rst_rdata",  P_RDATA, 32'h0);
        @(negedge P_CLK);
        P_RESET = 1'b0;
        align();

        // Basic write/read, back-to-back
        apb_xfer(1'b1, 32'h04, 32'h0BAD_F00D, "wr04");
        apb_xfer(1'b1, 32'h08, 32'hDEAD_BEEF, "wr08");
        apb_xfer(1'b0, 32'h08, 32'h0, "rd08");
        apb_xfer(1'b0, 32'h04, 32'h0, "rd04");

        // Reset asserted mid-cycle during a read's ACCESS phase
        P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b0; P_ADDR = 32'h08;
        align();
        P_ENABLE = 1'b1;
        #2;
        P_RESET = 1'b1;
        #1;
        check("mrst_ready",  32'(P_READY), 32'h0);
        check("mrst_slverr", 32'(P_SLVERR), 32'h0);
        check("mrst_rdata",  P_RDATA, 32'h0);
        model_clear();
        @(negedge P_CLK);
        P_RESET = 1'b0; P_SELx = 1'b0; P_ENABLE = 1'b0;
        align();
        apb_xfer(1'b0, 32'h04, 32'h0, "rd04_after_rst");

        // ID register
        apb_xfer(1'b0, 32'h00, 32'h0, "rd_id");
        apb_xfer(1'b1, 32'h00, 32'h1234_5678, "wr_id");
        apb_xfer(1'b0, 32'h00, 32'h0, "rd_id2");

        // Bad addresses and boundary
        apb_xfer(1'b1, 32'h04, 32'h1357_9BDF, "wr04b");
        apb_xfer(1'b0, 32'h40, 32'h0, "rd40");
        apb_xfer(1'b1, 32'h06, 32'hFFFF_FFFF, "wr06");
        apb_xfer(1'b0, 32'h04, 32'h0, "rd04b");
        apb_xfer(1'b1, 32'h3C, 32'hC0FF_EE00, "wr3c");
        apb_xfer(1'b0, 32'h3C, 32'h0, "rd3c");

        // Abort before the access strobe
        apb_xfer(1'b1, 32'h0C, 32'h1111_2222, "wr0c");
        P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = 32'h0C; P_WDATA = 32'h5555_5555;
        align();
        P_SELx = 1'b0;
        align();
        check("abort_ready", 32'(P_READY), 32'h0);
        apb_xfer(1'b0, 32'h0C, 32'h0, "rd0c");

        // Reset during ACCESS of a write
        apb_xfer(1'b1, 32'h10, 32'h7777_7777, "wr10");
        P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = 32'h10; P_WDATA = 32'hAAAA_AAAA;
        align();
        P_ENABLE = 1'b1;
        #2;
        P_RESET = 1'b1;
        #1;
        check("wrst_ready", 32'(P_READY), 32'h0);
        model_clear();
        @(negedge P_CLK);
        P_RESET = 1'b0;
        align();
        check("wrst_idle", 32'(P_READY), 32'h0);
        P_SELx = 1'b0; P_ENABLE = 1'b0;
        align();
        apb_xfer(1'b0, 32'h10, 32'h0, "rd10");
        apb_xfer(1'b0, 32'h08, 32'h0, "rd08_after_rst");

        // Random traffic against the model
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 17)) << 2;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            apb_xfer(1'($urandom_range(0, 1)), a, $urandom, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
